// File: rtl/mpy_pkg.sv
// Shared types and helpers for the multiplier accumulate path.
// sat_add works on a fixed wide container so one function serves any ACC_W below that width.
package mpy_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } acc_state_t;

    localparam int MPY_IN_W      = 64;
    localparam int MPY_ACC_W_DEF = 72;
    localparam int SAT_ADD_MAX_W = 128;

    typedef struct packed {
        logic [SAT_ADD_MAX_W-1:0] sum;
        logic                     ovf;
    } sat_add_t;

    // Operands and result occupy the low w bits; higher bits are ignored on input and zero on output.
    function automatic sat_add_t sat_add(input logic [SAT_ADD_MAX_W-1:0] a,
                                         input logic [SAT_ADD_MAX_W-1:0] b,
                                         input int                       w,
                                         input logic                     sat);
        sat_add_t                 r;
        logic [SAT_ADD_MAX_W-1:0] one;
        logic [SAT_ADD_MAX_W-1:0] mask;
        logic [SAT_ADD_MAX_W-1:0] sbit;
        logic [SAT_ADD_MAX_W-1:0] s;
        logic                     sa;
        logic                     sb;
        logic                     ss;
        one   = {{(SAT_ADD_MAX_W-1){1'b0}}, 1'b1};
        mask  = (w >= SAT_ADD_MAX_W) ? '1 : ((one << w) - one);
        sbit  = one << (w - 1);
        s     = (a + b) & mask;
        sa    = |(a & sbit);
        sb    = |(b & sbit);
        ss    = |(s & sbit);
        r.ovf = (sa == sb) && (ss != sa);
        r.sum = s;
        if (r.ovf && sat) begin
            r.sum = sa ? sbit : (mask >> 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/mpy_accumulator_sat_adder.sv
// W-bit signed adder with overflow detect and optional clamp to the signed range.
module sat_adder
    import mpy_pkg::*;
#(
    parameter int W   = MPY_ACC_W_DEF,
    parameter bit SAT = 1'b1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    sat_add_t res;
    logic     unused_hi;

    if (W >= SAT_ADD_MAX_W) begin : g_bad_w
        $error("sat_adder: W must be below SAT_ADD_MAX_W");
    end

    always_comb begin
        res = sat_add(SAT_ADD_MAX_W'(a_i), SAT_ADD_MAX_W'(b_i), W, SAT);
    end

    assign sum_o     = res.sum[W-1:0];
    assign ovf_o     = res.ovf;
    assign unused_hi = ^res.sum[SAT_ADD_MAX_W-1:W];

endmodule

// File: rtl/mpy_accumulator.sv
// Group accumulator behind the Booth multiplier: sums up to LEN signed products per group
// and holds each finished sum, its sticky overflow and its beat count on a valid/ready port.
module mpy_accumulator
    import mpy_pkg::*;
#(
    parameter int IN_W  = MPY_IN_W,
    parameter int ACC_W = MPY_ACC_W_DEF,
    parameter int LEN   = 16,
    parameter int SAT   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_data,
    output logic                     out_ovf,
    output logic [$clog2(LEN+1)-1:0] out_cnt
);

    localparam int CNT_W = $clog2(LEN+1);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

    logic [ACC_W-1:0] in_sext;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic [CNT_W-1:0] cnt_inc;
    logic             group_done;

    if (ACC_W <= IN_W) begin : g_bad_acc_w
        $error("mpy_accumulator: ACC_W must exceed IN_W");
    end
    if (LEN < 1) begin : g_bad_len
        $error("mpy_accumulator: LEN must be at least 1");
    end

    assign in_sext = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};

    // A clamped sum is written back to acc, so later beats keep adding to the clamp value.
    sat_adder #(
        .W   (ACC_W),
        .SAT (SAT != 0)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (in_sext),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign group_done = in_last || (cnt_inc == CNT_W'(LEN));

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        out_cnt_d  = out_cnt_q;
        if (clr) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (in_valid) begin
                        acc_d = add_sum;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | add_ovf;
                        if (group_done) begin
                            state_d    = HOLD;
                            out_data_d = add_sum;
                            out_ovf_d  = ovf_q | add_ovf;
                            out_cnt_d  = cnt_inc;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACC;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_mpy_accumulator.sv
// Scoreboard bench: three accumulators (72-bit saturating, 66-bit saturating, 66-bit wrapping)
// share one stimulus stream; a range-based reference model predicts every group result.
module tb_mpy_accumulator;

    localparam int LEN = 16;
    localparam int CW  = $clog2(LEN+1);
    localparam int NI  = 3;

    function automatic int wid(input int i);
        return (i == 0) ? 72 : 66;
    endfunction
    function automatic bit satm(input int i);
        return (i != 2);
    endfunction
    function automatic logic signed [127:0] pw2(input int n);
        return 128'sd1 <<< n;
    endfunction

    logic          clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [63:0]   in_data = '0;
    logic [NI-1:0] in_ready, out_valid, out_ovf;
    logic [CW-1:0] out_cnt [NI];
    logic [71:0]   d0;
    logic [65:0]   d1, d2;
    logic signed [127:0] out_d [NI];

    assign out_d[0] = {{56{d0[71]}}, d0};
    assign out_d[1] = {{62{d1[65]}}, d1};
    assign out_d[2] = {{62{d2[65]}}, d2};

    always #5 clk = ~clk;

    mpy_accumulator #(.IN_W(64), .ACC_W(72), .LEN(LEN), .SAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(d0), .out_ovf(out_ovf[0]), .out_cnt(out_cnt[0]));
    mpy_accumulator #(.IN_W(64), .ACC_W(66), .LEN(LEN), .SAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(d1), .out_ovf(out_ovf[1]), .out_cnt(out_cnt[1]));
    mpy_accumulator #(.IN_W(64), .ACC_W(66), .LEN(LEN), .SAT(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_data(d2), .out_ovf(out_ovf[2]), .out_cnt(out_cnt[2]));

    typedef struct packed {
        logic [NI-1:0][127:0] d;
        logic [NI-1:0]        o;
        logic [7:0]           c;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    bit   rnd_rdy = 1'b0;

    logic signed [127:0] m_acc [NI];
    bit                  m_ovf [NI];
    int                  m_cnt;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < NI; i++) begin
            m_acc[i] = '0;
            m_ovf[i] = 1'b0;
        end
        m_cnt = 0;
    endtask

    // Exact integer sum; leaving the signed range flags overflow, then clamp or fold by 2^W.
    task automatic mdl_accept(input logic [63:0] x, input bit last);
        logic signed [127:0] xs, s, hi, lo;
        exp_t e;
        xs = {{64{x[63]}}, x};
        for (int i = 0; i < NI; i++) begin
            hi = pw2(wid(i) - 1) - 1;
            lo = -pw2(wid(i) - 1);
            s  = m_acc[i] + xs;
            if (s > hi) begin
                m_ovf[i] = 1'b1;
                s = satm(i) ? hi : s - pw2(wid(i));
            end else if (s < lo) begin
                m_ovf[i] = 1'b1;
                s = satm(i) ? lo : s + pw2(wid(i));
            end
            m_acc[i] = s;
        end
        m_cnt++;
        if (last || m_cnt == LEN) begin
            for (int i = 0; i < NI; i++) begin
                e.d[i] = m_acc[i];
                e.o[i] = m_ovf[i];
            end
            e.c = 8'(m_cnt);
            sbq.push_back(e);
            mdl_reset();
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid[0]) begin
            if (clr) begin
                if (sbq.size() > 0) void'(sbq.pop_front());
            end else if (out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h expected none", out_d[0]);
                end else begin
                    e = sbq.pop_front();
                    for (int i = 0; i < NI; i++) begin
                        chk($sformatf("data[%0d]", i), out_d[i], e.d[i]);
                        chk($sformatf("ovf[%0d]", i), 128'(out_ovf[i]), 128'(e.o[i]));
                        chk($sformatf("cnt[%0d]", i), 128'(out_cnt[i]), 128'(e.c));
                        chk($sformatf("valid[%0d]", i), 128'(out_valid[i]), 128'd1);
                    end
                end
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (in_ready[0] !== 1'b1 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (in_ready[0] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got %b expected 1", in_ready[0]);
        end
    endtask

    task automatic beat(input logic [63:0] x, input bit last);
        wait_ready();
        in_valid = 1'b1;
        in_data  = x;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_data  = {$urandom, $urandom};
        mdl_accept(x, last);
    endtask

    task automatic drain();
        int t = 0;
        out_ready = 1'b1;
        while (sbq.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [63:0] x;
        int          len;
        mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_in_ready", 128'(in_ready[i]), 128'd1);
            chk("rst_out_valid", 128'(out_valid[i]), 128'd0);
            chk("rst_out_data", out_d[i], 128'd0);
            chk("rst_out_ovf", 128'(out_ovf[i]), 128'd0);
            chk("rst_out_cnt", 128'(out_cnt[i]), 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3, -5, 7(last) with latency check around the final beat
        out_ready = 1'b1;
        beat(64'd3, 1'b0);
        beat(-64'sd5, 1'b0);
        wait_ready();
        in_valid = 1'b1;
        in_data  = 64'd7;
        in_last  = 1'b1;
        @(negedge clk);
        chk("lat_before_edge", 128'(out_valid[0]), 128'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        mdl_accept(64'd7, 1'b1);
        chk("lat_after_edge", 128'(out_valid[0]), 128'd1);
        chk("lat_in_ready_hold", 128'(in_ready[0]), 128'd0);
        @(posedge clk);
        #1;
        chk("lat_in_ready_k2", 128'(in_ready[0]), 128'd1);

        // full group without in_last
        for (int i = 0; i < LEN; i++) beat(64'h3FFF_FFFF_0000_0001, 1'b0);
        chk("full_group_hold", 128'(out_valid[0]), 128'd1);

        // positive overflow in the 66-bit instances
        for (int i = 0; i < 5; i++) beat(64'h7FFF_FFFF_FFFF_FFFF, i == 4);

        // backpressure: held result must not move and beats must not be taken
        drain();
        out_ready = 1'b0;
        beat(64'd6, 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 64'd9;
            in_last  = 1'b1;
            @(negedge clk);
            chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
            chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
            chk("bp_out_data", out_d[0], 128'd6);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        beat(64'd4, 1'b0);
        beat(64'd4, 1'b1);

        // clr drops the partial sum and a same-cycle beat
        beat(64'd1, 1'b0);
        beat(64'd2, 1'b0);
        wait_ready();
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'd100;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        mdl_reset();
        beat(64'd10, 1'b1);

        // clr discards a held result without handshake
        drain();
        out_ready = 1'b0;
        beat(64'd5, 1'b1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_hold_drop", 128'(out_valid[0]), 128'd0);
        chk("clr_hold_sb", 128'(sbq.size()), 128'd0);
        out_ready = 1'b1;
        beat(64'd11, 1'b1);

        // random groups, extremes mixed in, random backpressure and occasional clr
        rnd_rdy = 1'b1;
        for (int g = 0; g < 40; g++) begin
            len = $urandom_range(1, 20);
            for (int b = 0; b < len; b++) begin
                case ($urandom_range(0, 3))
                    0:       x = 64'h7FFF_FFFF_FFFF_FFFF;
                    1:       x = 64'h8000_0000_0000_0000;
                    default: x = {$urandom, $urandom};
                endcase
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                beat(x, b == len - 1);
            end
            if ($urandom_range(0, 29) == 0) begin
                clr = 1'b1;
                @(posedge clk);
                #1;
                clr = 1'b0;
                mdl_reset();
            end
        end
        rnd_rdy = 1'b0;
        drain();

        // async reset while holding a result
        out_ready = 1'b0;
        beat(64'd77, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("arst_in_ready", 128'(in_ready[0]), 128'd1);
        chk("arst_out_data", out_d[0], 128'd0);
        chk("arst_out_cnt", 128'(out_cnt[0]), 128'd0);
        sbq.delete();
        mdl_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        beat(64'd3, 1'b1);
        drain();
        @(posedge clk);
        #1;
        chk("sb_empty", 128'(sbq.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
